// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input and register-write output bundle for uart_cmd_ctrl.
// The slave modport is the controller's view. The master modport is the
// view of whatever feeds it bytes and watches its writes.
interface uart_cmd_ctrl_if;
  logic       rcv;
  logic [7:0] data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  modport slave (
    input  rcv, data,
    output wr_en, wr_addr, wr_data, frame_err, err_cnt, busy
  );

  modport master (
    output rcv, data,
    input  wr_en, wr_addr, wr_data, frame_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame controller behind uart_rx. It collects {SYNC, ADDR, DATA, CHK} byte
// frames and turns each valid frame into a one-cycle register-write strobe.
// A bad checksum or an inter-byte silence of TIMEOUT cycles drops the frame.
// Either case raises frame_err and bumps a saturating error counter.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 12000,
  parameter int         TO_W    = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  uart_cmd_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA} state_e;

  state_e          state_q, state_d;
  logic [7:0]      addrLatch_q, addrLatch_d;
  logic [7:0]      dataLatch_q, dataLatch_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            wrEn_q, wrEn_d;
  logic            frameErr_q, frameErr_d;
  logic [7:0]      wrAddr_q, wrAddr_d;
  logic [7:0]      wrData_q, wrData_d;
  logic [7:0]      errCnt_q, errCnt_d;

  logic            timeoutHit;
  logic            chkOk;

  // A frame expires only when no byte arrives on the expiry cycle.
  // A byte arriving on that cycle takes priority over the expiry.
  assign timeoutHit = (state_q != IDLE) && !bus.rcv &&
                      (toCnt_q == TO_W'(TIMEOUT - 1));
  assign chkOk      = (bus.data == (SYNC ^ addrLatch_q ^ dataLatch_q));

  // State and all registered outputs, with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      addrLatch_q <= 8'h00;
      dataLatch_q <= 8'h00;
      toCnt_q     <= '0;
      wrEn_q      <= 1'b0;
      frameErr_q  <= 1'b0;
      wrAddr_q    <= 8'h00;
      wrData_q    <= 8'h00;
      errCnt_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      addrLatch_q <= addrLatch_d;
      dataLatch_q <= dataLatch_d;
      toCnt_q     <= toCnt_d;
      wrEn_q      <= wrEn_d;
      frameErr_q  <= frameErr_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      errCnt_q    <= errCnt_d;
    end
  end

  // Next-state decode. A SYNC byte seen mid-frame is treated as payload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.rcv && bus.data == SYNC) state_d = GOT_SYNC;
      GOT_SYNC: if (bus.rcv) state_d = GOT_ADDR; else if (timeoutHit) state_d = IDLE;
      GOT_ADDR: if (bus.rcv) state_d = GOT_DATA; else if (timeoutHit) state_d = IDLE;
      GOT_DATA: if (bus.rcv || timeoutHit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and output decode: latches, timeout counter, strobes and error count
  always_comb begin
    addrLatch_d = addrLatch_q;
    dataLatch_d = dataLatch_q;
    wrEn_d      = 1'b0;
    frameErr_d  = 1'b0;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    toCnt_d     = '0;

    if (state_q != IDLE && state_d != IDLE && !bus.rcv) begin
      toCnt_d = toCnt_q + TO_W'(1);
    end

    case (state_q)
      GOT_SYNC: if (bus.rcv) addrLatch_d = bus.data;
      GOT_ADDR: if (bus.rcv) dataLatch_d = bus.data;
      GOT_DATA: begin
        if (bus.rcv) begin
          if (chkOk) begin
            wrEn_d   = 1'b1;
            wrAddr_d = addrLatch_q;
            wrData_d = dataLatch_q;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (timeoutHit) frameErr_d = 1'b1;

    errCnt_d = errCnt_q;
    if (frameErr_d && errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
  end

  assign bus.wr_en     = wrEn_q;
  assign bus.wr_addr   = wrAddr_q;
  assign bus.wr_data   = wrData_q;
  assign bus.frame_err = frameErr_q;
  assign bus.err_cnt   = errCnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl. An expected write or error event is
// queued whenever the byte that should cause it is driven. A negedge monitor
// pops and compares the queue each time the DUT raises wr_en or frame_err.
module tb_uart_cmd_ctrl;
  localparam int TB_TIMEOUT = 40;

  logic clk;
  logic rstn;
  uart_cmd_ctrl_if ifc ();

  uart_cmd_ctrl #(.SYNC(8'hA5), .TIMEOUT(TB_TIMEOUT), .TO_W(16)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (ifc)
  );

  typedef struct {
    bit         isWrite;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] errCnt;
  } expEvt_t;

  expEvt_t sbQ[$];
  int totalCount = 0;
  int badCount   = 0;
  logic [7:0] expWrAddr = 8'h00;
  logic [7:0] expWrData = 8'h00;
  logic [7:0] expErrCnt = 8'h00;

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWrite(input logic [7:0] a, input logic [7:0] d);
    expEvt_t e;
    expWrAddr = a;
    expWrData = d;
    e.isWrite = 1'b1; e.addr = a; e.data = d; e.errCnt = expErrCnt;
    sbQ.push_back(e);
  endtask

  task automatic pushErr();
    expEvt_t e;
    if (expErrCnt != 8'hFF) expErrCnt = expErrCnt + 8'd1;
    e.isWrite = 1'b0; e.addr = expWrAddr; e.data = expWrData; e.errCnt = expErrCnt;
    sbQ.push_back(e);
  endtask

  // Called at a negedge. The byte is sampled on the following posedge.
  task automatic applyStimulus(input logic [7:0] b);
    ifc.rcv  = 1'b1;
    ifc.data = b;
    @(negedge clk);
    ifc.rcv  = 1'b0;
    ifc.data = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] s, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] c);
    applyStimulus(s); idleCycles(1);
    applyStimulus(a); idleCycles(1);
    applyStimulus(d); idleCycles(1);
    applyStimulus(c);
  endtask

  task automatic applyReset(input int n);
    rstn = 1'b0;
    idleCycles(n);
    rstn = 1'b1;
    expWrAddr = 8'h00;
    expWrData = 8'h00;
    expErrCnt = 8'h00;
  endtask

  task automatic drain();
    int waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("sbDrain", sbQ.size(), 0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (rstn === 1'b1 && (ifc.wr_en || ifc.frame_err)) begin
      expEvt_t e;
      checkOutput("exclusive", {31'd0, ifc.wr_en & ifc.frame_err}, 0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedEvt", {30'd0, ifc.wr_en, ifc.frame_err}, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("evtWrEn", {31'd0, ifc.wr_en}, {31'd0, e.isWrite});
        checkOutput("evtFrameErr", {31'd0, ifc.frame_err}, {31'd0, !e.isWrite});
        checkOutput("evtAddr", {24'd0, ifc.wr_addr}, {24'd0, e.addr});
        checkOutput("evtData", {24'd0, ifc.wr_data}, {24'd0, e.data});
        checkOutput("evtErrCnt", {24'd0, ifc.err_cnt}, {24'd0, e.errCnt});
      end
    end
  end

  initial begin
    ifc.rcv  = 1'b0;
    ifc.data = 8'h00;
    rstn     = 1'b0;
    @(negedge clk);

    // Reset state
    applyReset(2);
    checkOutput("rstWrEn", {31'd0, ifc.wr_en}, 0);
    checkOutput("rstFrameErr", {31'd0, ifc.frame_err}, 0);
    checkOutput("rstAddr", {24'd0, ifc.wr_addr}, 0);
    checkOutput("rstData", {24'd0, ifc.wr_data}, 0);
    checkOutput("rstErrCnt", {24'd0, ifc.err_cnt}, 0);
    checkOutput("rstBusy", {31'd0, ifc.busy}, 0);

    // Good frame
    applyStimulus(8'hA5);
    checkOutput("busyAfterSync", {31'd0, ifc.busy}, 1);
    idleCycles(1);
    applyStimulus(8'h10); idleCycles(1);
    applyStimulus(8'h3C); idleCycles(1);
    pushWrite(8'h10, 8'h3C);
    applyStimulus(8'h89);
    checkOutput("busyAfterChk", {31'd0, ifc.busy}, 0);
    drain();
    checkOutput("goodErrCnt", {24'd0, ifc.err_cnt}, 0);

    // Bad checksum keeps the previous write address/data
    pushErr();
    sendFrame(8'hA5, 8'h10, 8'h3C, 8'h88);
    drain();
    checkOutput("badHoldAddr", {24'd0, ifc.wr_addr}, 8'h10);

    // Timeout after A5,10 followed by a good frame
    applyStimulus(8'hA5); idleCycles(1);
    applyStimulus(8'h10);
    idleCycles(TB_TIMEOUT - 1);
    checkOutput("busyBeforeExpiry", {31'd0, ifc.busy}, 1);
    pushErr();
    idleCycles(1);
    checkOutput("busyAfterExpiry", {31'd0, ifc.busy}, 0);
    drain();
    pushWrite(8'h01, 8'h02);
    sendFrame(8'hA5, 8'h01, 8'h02, 8'hA6);
    drain();

    // A byte arriving on the expiry cycle wins over the timeout
    applyStimulus(8'hA5);
    idleCycles(TB_TIMEOUT - 1);
    applyStimulus(8'h10);
    idleCycles(TB_TIMEOUT - 1);
    applyStimulus(8'h3C);
    checkOutput("busyRcvOnExpiry", {31'd0, ifc.busy}, 1);
    pushWrite(8'h10, 8'h3C);
    applyStimulus(8'h89);
    drain();

    // A SYNC in the cycle right after a CHK starts a new frame
    applyStimulus(8'hA5); applyStimulus(8'h55); applyStimulus(8'h66);
    pushWrite(8'h55, 8'h66);
    applyStimulus(8'h96);
    applyStimulus(8'hA5); applyStimulus(8'h77); applyStimulus(8'h88);
    pushWrite(8'h77, 8'h88);
    applyStimulus(8'h5A);
    drain();

    // Junk bytes are ignored, and SYNC in payload positions is plain data
    applyStimulus(8'h00); applyStimulus(8'hFF);
    checkOutput("junkIdle", {31'd0, ifc.busy}, 0);
    applyStimulus(8'hA5); applyStimulus(8'hA5); applyStimulus(8'hA5);
    pushErr();
    applyStimulus(8'h00);
    drain();

    // Reset mid-frame discards the partial frame
    applyStimulus(8'hA5); applyStimulus(8'h10);
    applyReset(1);
    checkOutput("midRstBusy", {31'd0, ifc.busy}, 0);
    checkOutput("midRstErrCnt", {24'd0, ifc.err_cnt}, 0);
    checkOutput("midRstAddr", {24'd0, ifc.wr_addr}, 0);
    pushWrite(8'h20, 8'h30);
    sendFrame(8'hA5, 8'h20, 8'h30, 8'hB5);
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      pushErr();
      sendFrame(8'hA5, 8'h00, 8'h00, 8'h00);
    end
    drain();
    checkOutput("satErrCnt", {24'd0, ifc.err_cnt}, 8'hFF);
    checkOutput("satHoldData", {24'd0, ifc.wr_data}, 8'h30);

    idleCycles(3);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
